// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time round sequencer.
// State encoding, LFSR seed/taps and a log2 helper for the averaging shift.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT,
    LIT,
    SHOW,
    DONE
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // x^16+x^14+x^13+x^11+1 on a register shifting toward bit 0
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/reaction_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR feeding the random wait delay.
// A zero state can only come from a fault and is steered back to the seed.
module reaction_lfsr16
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic        w_fb;

  assign w_fb = ^(r_q & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= LFSR_SEED;
    end else if (r_q == '0) begin
      r_q <= LFSR_SEED;
    end else begin
      r_q <= {w_fb, r_q[15:1]};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/reaction_round_sequencer.sv
// Multi-round reaction game controller: random wait, LED, latency
// measurement in ms, false-start/timeout detection, best and average.
module reaction_round_sequencer
  import reaction_pkg::*;
#(
  parameter int CLK_PER_MS     = 10000,
  parameter int ROUNDS         = 4,
  parameter int MIN_DELAY_MS   = 500,
  parameter int DELAY_RANGE_MS = 1024,
  parameter int HOLD_MS        = 1000,
  parameter int TIME_W         = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              button,
  input  logic              abort,
  output logic              led,
  output logic              busy,
  output logic [3:0]        round_idx,
  output logic [TIME_W-1:0] result_ms,
  output logic              result_valid,
  output logic              false_start,
  output logic [TIME_W-1:0] best_ms,
  output logic [TIME_W-1:0] avg_ms,
  output logic              done
);

  localparam int PS_W  = clog2(CLK_PER_MS);
  localparam int DLY_W = clog2(MIN_DELAY_MS + DELAY_RANGE_MS);
  localparam int HLD_W = clog2(HOLD_MS + 1);
  localparam int SUM_W = TIME_W + 4;
  localparam int RSH   = clog2(ROUNDS);

  localparam logic [TIME_W-1:0] MAX_MS    = '1;
  localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(CLK_PER_MS - 1);
  localparam logic [HLD_W-1:0]  HOLD_LAST = HLD_W'(HOLD_MS - 1);
  localparam logic [3:0]        RND_LAST  = 4'(ROUNDS - 1);

  state_t r_state;
  state_t w_state_n;

  logic [15:0]       w_lfsr;
  logic [PS_W-1:0]   r_ps;
  logic [DLY_W-1:0]  r_dly;
  logic [DLY_W-1:0]  w_dly_load;
  logic [TIME_W-1:0] r_ms;
  logic [HLD_W-1:0]  r_hold;
  logic [SUM_W-1:0]  r_sum;
  logic [3:0]        r_round;
  logic [TIME_W-1:0] r_result;
  logic [TIME_W-1:0] r_best;
  logic [TIME_W-1:0] r_avg;
  logic              r_rv;
  logic              r_fs;
  logic              r_led;
  logic              r_start_q;
  logic              r_btn_q;

  logic w_go;
  logic w_press;
  logic w_tick;
  logic w_new_game;
  logic w_load_dly;
  logic w_dly_dec;
  logic w_fs;
  logic w_lit;
  logic w_hit;
  logic w_tmo;
  logic w_ms_inc;
  logic w_hold_inc;
  logic w_next;
  logic w_finish;

  reaction_lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (w_lfsr)
  );

  assign w_go    = start & ~r_start_q;
  assign w_press = button & ~r_btn_q;
  assign w_tick  = (r_ps == PS_LAST);

  assign w_dly_load = DLY_W'(MIN_DELAY_MS)
                    + DLY_W'(w_lfsr & 16'(DELAY_RANGE_MS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // abort overrides every strobe so no result or done can leak out
  always_comb begin
    w_state_n  = r_state;
    w_new_game = 1'b0;
    w_load_dly = 1'b0;
    w_dly_dec  = 1'b0;
    w_fs       = 1'b0;
    w_lit      = 1'b0;
    w_hit      = 1'b0;
    w_tmo      = 1'b0;
    w_ms_inc   = 1'b0;
    w_hold_inc = 1'b0;
    w_next     = 1'b0;
    w_finish   = 1'b0;
    if (abort && (r_state != IDLE)) begin
      w_state_n = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_go) begin
            w_new_game = 1'b1;
            w_state_n  = ARM;
          end
        end
        ARM: begin
          if (!button) begin
            w_load_dly = 1'b1;
            w_state_n  = WAIT;
          end
        end
        WAIT: begin
          if (w_press) begin
            w_fs      = 1'b1;
            w_state_n = SHOW;
          end else if (r_dly == '0) begin
            w_lit     = 1'b1;
            w_state_n = LIT;
          end else if (w_tick) begin
            w_dly_dec = 1'b1;
          end
        end
        LIT: begin
          if (w_press) begin
            w_hit     = 1'b1;
            w_state_n = SHOW;
          end else if (r_ms == MAX_MS) begin
            w_tmo     = 1'b1;
            w_state_n = SHOW;
          end else if (w_tick) begin
            w_ms_inc = 1'b1;
          end
        end
        SHOW: begin
          if (w_tick) begin
            if (r_hold != HOLD_LAST) begin
              w_hold_inc = 1'b1;
            end else if (r_round == RND_LAST) begin
              w_finish  = 1'b1;
              w_state_n = DONE;
            end else begin
              w_next    = 1'b1;
              w_state_n = ARM;
            end
          end
        end
        DONE: begin
          w_state_n = IDLE;
        end
        default: begin
          w_state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (w_state_n != r_state) || w_tick) begin
      r_ps <= '0;
    end else begin
      r_ps <= r_ps + PS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_q <= 1'b0;
      r_btn_q   <= 1'b0;
      r_dly     <= '0;
      r_ms      <= '0;
      r_hold    <= '0;
      r_sum     <= '0;
      r_round   <= '0;
      r_result  <= '0;
      r_best    <= MAX_MS;
      r_avg     <= '0;
      r_rv      <= 1'b0;
      r_fs      <= 1'b0;
      r_led     <= 1'b0;
    end else begin
      r_start_q <= start;
      r_btn_q   <= button;
      r_rv      <= 1'b0;
      r_led     <= (w_state_n == LIT);
      if (w_new_game) begin
        r_round <= '0;
        r_sum   <= '0;
        r_best  <= MAX_MS;
        r_fs    <= 1'b0;
      end
      if (w_load_dly) begin
        r_dly <= w_dly_load;
      end else if (w_dly_dec) begin
        r_dly <= r_dly - DLY_W'(1);
      end
      if (w_lit) begin
        r_ms <= '0;
      end else if (w_ms_inc) begin
        r_ms <= r_ms + TIME_W'(1);
      end
      // false start and timeout both score as the worst time
      if (w_fs || w_tmo) begin
        r_result <= MAX_MS;
        r_rv     <= 1'b1;
        r_sum    <= r_sum + SUM_W'(MAX_MS);
      end
      if (w_fs) begin
        r_fs <= 1'b1;
      end
      if (w_hit) begin
        r_result <= r_ms;
        r_rv     <= 1'b1;
        r_sum    <= r_sum + SUM_W'(r_ms);
        if (r_ms < r_best) begin
          r_best <= r_ms;
        end
      end
      if (w_fs || w_hit || w_tmo) begin
        r_hold <= '0;
      end else if (w_hold_inc) begin
        r_hold <= r_hold + HLD_W'(1);
      end
      if (w_next) begin
        r_round <= r_round + 4'd1;
      end
      if (w_finish) begin
        r_avg <= TIME_W'(r_sum >> RSH);
      end
    end
  end

  assign led          = r_led;
  assign busy         = (r_state != IDLE);
  assign round_idx    = r_round;
  assign result_ms    = r_result;
  assign result_valid = r_rv;
  assign false_start  = r_fs;
  assign best_ms      = r_best;
  assign avg_ms       = r_avg;
  assign done         = (r_state == DONE);

endmodule

// File: tb/tb_reaction_round_sequencer.sv
// Bench for reaction_round_sequencer: directed games with random press
// timing checked against an arithmetic per-game model.
module tb_reaction_round_sequencer;

  localparam int CPM  = 4;
  localparam int RND  = 2;
  localparam int MIN  = 2;
  localparam int RNG  = 4;
  localparam int HOLD = 2;
  localparam int TW   = 8;
  localparam int MAXV = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          button;
  logic          abort;
  logic          led;
  logic          busy;
  logic [3:0]    ridx;
  logic [TW-1:0] res;
  logic          rv;
  logic          fs;
  logic [TW-1:0] best;
  logic [TW-1:0] avg;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_lfsr;
  int g_sum;
  int g_best;
  int g_fs;
  int g_last;

  always #5 clk = ~clk;

  reaction_round_sequencer #(
    .CLK_PER_MS     (CPM),
    .ROUNDS         (RND),
    .MIN_DELAY_MS   (MIN),
    .DELAY_RANGE_MS (RNG),
    .HOLD_MS        (HOLD),
    .TIME_W         (TW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .button       (button),
    .abort        (abort),
    .led          (led),
    .busy         (busy),
    .round_idx    (ridx),
    .result_ms    (res),
    .result_valid (rv),
    .false_start  (fs),
    .best_ms      (best),
    .avg_ms       (avg),
    .done         (done)
  );

  // x^16+x^14+x^13+x^11+1, new bit enters at the top
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  always @(posedge clk) begin
    m_lfsr <= rst ? 16'hACE1 : lfsr_next(m_lfsr);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_game();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("go_busy", busy, 1);
    chk("go_round", ridx, 0);
    chk("go_best", best, MAXV);
    chk("go_fs", fs, 0);
    g_sum  = 0;
    g_best = MAXV;
    g_fs   = 0;
  endtask

  // mode 0: press arg cycles into LIT; 1: press in WAIT (arg<0 = last
  // WAIT cycle); 2: never press; 3: abort on the first LIT cycle
  task automatic to_show(input int mode, input int arg, input int r);
    int d;
    int k;
    int exp_res;
    bit seen;
    d = MIN + int'(m_lfsr & 16'(RNG - 1));
    chk("arm_round", ridx, r);
    if (mode == 1) begin
      k = (arg < 0) ? CPM * d + 1 : 1 + arg % (CPM * d + 1);
      seen = 1'b0;
      for (int i = 0; i < k; i++) begin
        @(negedge clk);
        if (led) seen = 1'b1;
      end
      button = 1'b1;
      @(negedge clk);
      chk("fs_led_never", seen, 0);
      exp_res = MAXV;
      g_fs = 1;
    end else begin
      k = 0;
      while (!led && k < CPM * (MIN + RNG) + 8) begin
        @(negedge clk);
        k++;
      end
      chk("led_latency", k, CPM * d + 2);
      if (mode == 3) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_led", led, 0);
        chk("abort_rv", rv, 0);
        chk("abort_done", done, 0);
        chk("abort_res", res, g_last);
        return;
      end
      if (mode == 0) begin
        repeat (arg) @(negedge clk);
        chk("lit_led", led, 1);
        button = 1'b1;
        @(negedge clk);
        exp_res = arg / CPM;
      end else begin
        k = 0;
        while (!rv && k < 1100) begin
          @(negedge clk);
          k++;
        end
        chk("timeout_cycles", k, CPM * MAXV + 1);
        exp_res = MAXV;
      end
    end
    chk("rv", rv, 1);
    chk("result", res, exp_res);
    chk("show_led", led, 0);
    chk("fs_flag", fs, g_fs);
    g_sum += exp_res;
    if (mode == 0 && exp_res < g_best) g_best = exp_res;
    g_last = exp_res;
  endtask

  task automatic finish_round(input int r);
    int k;
    button = 1'b0;
    @(negedge clk);
    k = 1;
    chk("rv_pulse", rv, 0);
    chk("show_round", ridx, r);
    while (!done && ridx == 4'(r) && k < CPM * HOLD + 8) begin
      @(negedge clk);
      k++;
    end
    chk("hold_cycles", k, CPM * HOLD);
    if (r == RND - 1) begin
      chk("done", done, 1);
      chk("avg", avg, g_sum / RND);
      chk("best", best, g_best);
      chk("fs_end", fs, g_fs);
      chk("res_hold", res, g_last);
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("busy_end", busy, 0);
    end else begin
      chk("next_round", ridx, r + 1);
      chk("next_busy", busy, 1);
      chk("no_done", done, 0);
    end
  endtask

  task automatic play(input int m0, input int a0, input int m1,
                      input int a1);
    start_game();
    to_show(m0, a0, 0);
    finish_round(0);
    to_show(m1, a1, 1);
    finish_round(1);
  endtask

  initial begin
    int m;
    int a;
    int md[RND];
    int ar[RND];
    bit seen;
    rst    = 1'b1;
    start  = 1'b0;
    button = 1'b0;
    abort  = 1'b0;
    g_last = 0;
    repeat (2) @(negedge clk);
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_round", ridx, 0);
    chk("rst_res", res, 0);
    chk("rst_rv", rv, 0);
    chk("rst_fs", fs, 0);
    chk("rst_done", done, 0);
    chk("rst_avg", avg, 0);
    chk("rst_best", best, MAXV);
    rst = 1'b0;
    @(negedge clk);

    // two 9 ms presses
    play(0, int'($urandom_range(36, 39)), 0, int'($urandom_range(36, 39)));

    // false start then 5 ms; go while busy during the first SHOW
    start_game();
    to_show(1, int'($urandom_range(0, 100)), 0);
    start = 1'b1;
    finish_round(0);
    start = 1'b0;
    to_show(0, int'($urandom_range(20, 23)), 1);
    finish_round(1);

    // timeout, then press exactly on delay expiry
    play(2, 0, 1, -1);

    // press coinciding with the tick at ms_cnt=3
    play(0, 15, 0, int'($urandom_range(0, 200)));

    for (int g = 0; g < 3; g++) begin
      for (int r = 0; r < RND; r++) begin
        m = int'($urandom_range(0, 1));
        a = (m == 0) ? int'($urandom_range(0, 300))
                     : int'($urandom_range(0, 1000));
        md[r] = m;
        ar[r] = a;
      end
      play(md[0], ar[0], md[1], ar[1]);
    end

    // abort while lit
    start_game();
    to_show(3, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy || led) seen = 1'b1;
    end
    chk("abort_quiet", seen, 0);

    // reset in the middle of SHOW
    start_game();
    to_show(0, int'($urandom_range(0, 60)), 0);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    button = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_led", led, 0);
    chk("mid_rst_res", res, 0);
    chk("mid_rst_best", best, MAXV);
    chk("mid_rst_round", ridx, 0);
    chk("mid_rst_rv", rv, 0);
    chk("mid_rst_avg", avg, 0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
